// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder memory-bus responder.
package mem_resp_pkg;

  localparam int DEF_ADDR_W      = 5;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_WAIT_STATES = 1;
  localparam int CNT_W           = 4;
  localparam int ACC_W           = 16;
  localparam logic [ACC_W-1:0] ACC_MAX = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] v);
    return (v == ACC_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Storage for mem_responder: one write port, one registered read port.
// With MEM_RESP_PARITY_EN each word carries an even-parity bit.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef MEM_RESP_PARITY_EN
  input  logic              wr_par,
  output logic              rd_perr,
`endif
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the whole array is reset, so it maps to flops rather than a RAM macro;
  // this is the price of guaranteeing all-zero contents after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

`ifdef MEM_RESP_PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) par[i] <= 1'b0;
    end else if (wr_en) begin
      par[wr_addr] <= wr_par;
    end
  end

  // Stored bit equals XOR of the data when healthy, so any difference is an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_perr <= 1'b0;
    else if (rd_en) rd_perr <= (^mem[rd_addr]) ^ par[rd_addr];
  end
`endif

endmodule

// File: rtl/mem_responder.sv
// Responder end of the memory bus: request FSM with programmable wait states,
// sticky protocol-error flags and a saturating access counter. Optional parity: MEM_RESP_PARITY_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MEM_RESP_PARITY_EN
  input  logic              inj_perr,
  output logic              rd_perr,
`endif
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              rd_valid,
  output logic              err_collision,
  output logic              err_overrun,
  output logic [ACC_W-1:0]  acc_count
);

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t            state_q, state_d;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept, collide, overrun, resp;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    collide = 1'b0;
    overrun = 1'b0;
    resp    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read && write) begin
          collide = 1'b1;
        end else if (read || write) begin
          accept  = 1'b1;
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        overrun = read || write;
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        overrun = read || write;
        resp    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= OP_RD;
      addr_q        <= '0;
      data_q        <= '0;
      cnt_q         <= '0;
      ready         <= 1'b0;
      rd_valid      <= 1'b0;
      err_collision <= 1'b0;
      err_overrun   <= 1'b0;
      acc_count     <= '0;
    end else begin
      state_q  <= state_d;
      ready    <= resp;
      rd_valid <= resp && (op_q == OP_RD);
      if (collide) err_collision <= 1'b1;
      if (overrun) err_overrun   <= 1'b1;
      if (accept) begin
        op_q   <= write ? OP_WR : OP_RD;
        addr_q <= addr;
        data_q <= data_in;
        cnt_q  <= WAIT_LOAD;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (resp) acc_count <= sat_inc(acc_count);
    end
  end

`ifdef MEM_RESP_PARITY_EN
  logic inj_q;
  logic arr_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      inj_q <= 1'b0;
    else if (accept) inj_q <= inj_perr;
  end

  // The array flag holds between reads; qualify it so it only pulses with rd_valid.
  assign rd_perr = rd_valid & arr_perr;
`endif

  mem_resp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (resp && (op_q == OP_WR)),
    .wr_addr (addr_q),
    .wr_data (data_q),
`ifdef MEM_RESP_PARITY_EN
    .wr_par  ((^data_q) ^ inj_q),
    .rd_perr (arr_perr),
`endif
    .rd_en   (resp && (op_q == OP_RD)),
    .rd_addr (addr_q),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed corner cases plus random
// accesses checked against an array-based reference model.
module tb_mem_responder;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int WS    = 1;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          ready;
  logic          rd_valid;
  logic          err_collision;
  logic          err_overrun;
  logic [15:0]   acc_count;
`ifdef MEM_RESP_PARITY_EN
  logic          inj_perr = 1'b0;
  logic          rd_perr;
  logic          perr_model [DEPTH];
`endif

  mem_responder #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WAIT_STATES (WS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef MEM_RESP_PARITY_EN
    .inj_perr      (inj_perr),
    .rd_perr       (rd_perr),
`endif
    .read          (read),
    .write         (write),
    .addr          (addr),
    .data_in       (data_in),
    .data_out      (data_out),
    .ready         (ready),
    .rd_valid      (rd_valid),
    .err_collision (err_collision),
    .err_overrun   (err_overrun),
    .acc_count     (acc_count)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] mem_model [DEPTH];
  int            acc_model = 0;
  logic          exp_col = 1'b0;
  logic          exp_ovr = 1'b0;
  logic [DW-1:0] exp_dout = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mem_model[i] = '0;
`ifdef MEM_RESP_PARITY_EN
      perr_model[i] = 1'b0;
`endif
    end
    acc_model = 0;
    exp_col   = 1'b0;
    exp_ovr   = 1'b0;
    exp_dout  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, data_out, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_rdvalid"}, rd_valid, 0);
    check({tag, "_errcol"}, err_collision, 0);
    check({tag, "_errovr"}, err_overrun, 0);
    check({tag, "_acc"}, acc_count, 0);
  endtask

  // Called just after a clock edge; returns after the edge that raised ready.
  task automatic wait_ready(input string tag);
    int lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, WS + 1);
  endtask

  task automatic access(input logic is_wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic inj);
    read    = !is_wr;
    write   = is_wr;
    addr    = a;
    data_in = d;
`ifdef MEM_RESP_PARITY_EN
    inj_perr = inj;
`endif
    @(posedge clk); #1;
    read  = 1'b0;
    write = 1'b0;
`ifdef MEM_RESP_PARITY_EN
    inj_perr = 1'b0;
`endif
    wait_ready(is_wr ? "wr" : "rd");
    if (acc_model < 65535) acc_model++;
    if (is_wr) begin
      mem_model[a] = d;
`ifdef MEM_RESP_PARITY_EN
      perr_model[a] = inj;
      check("wr_rdperr", rd_perr, 0);
`endif
      check("wr_rdvalid", rd_valid, 0);
      check("wr_dout_hold", data_out, exp_dout);
    end else begin
      exp_dout = mem_model[a];
      check("rd_rdvalid", rd_valid, 1);
      check("rd_data", data_out, exp_dout);
`ifdef MEM_RESP_PARITY_EN
      check("rd_perr", rd_perr, perr_model[a]);
`endif
    end
    check("acc_count", acc_count, acc_model);
    check("err_col_state", err_collision, exp_col);
    check("err_ovr_state", err_overrun, exp_ovr);
  endtask

  task automatic count_ready(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    model_reset();

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-fill then read back
    for (int i = 0; i < DEPTH; i++) access(1'b1, AW'(i), 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) access(1'b0, AW'(i), 8'hFF, 1'b0);
    check("acc_after_64", acc_count, 64);

    // data = address pattern
    for (int i = 0; i < DEPTH; i++) access(1'b1, AW'(i), DW'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) access(1'b0, AW'(i), 8'h00, 1'b0);

    // Random traffic with random idle gaps
    for (int n = 0; n < 80; n++) begin
      access(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
             DW'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Collision at addr 3: no access, flag set, memory untouched
    access(1'b1, 5'd3, 8'h33, 1'b0);
    read = 1'b1; write = 1'b1; addr = 5'd3; data_in = 8'hEE;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    exp_col = 1'b1;
    count_ready(4, seen);
    check("col_no_ready", seen, 0);
    check("col_flag", err_collision, 1);
    check("col_no_ovr", err_overrun, 0);
    check("col_acc", acc_count, acc_model);
    access(1'b0, 5'd3, 8'h00, 1'b0);

    // Overrun: read strobe during WAIT of a write is dropped
    write = 1'b1; addr = 5'd5; data_in = 8'hA5;
    @(posedge clk); #1;
    write = 1'b0; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    exp_ovr = 1'b1;
    check("ovr_ready_early", ready, 0);
    @(posedge clk); #1;
    check("ovr_ready", ready, 1);
    check("ovr_rdvalid", rd_valid, 0);
    check("ovr_flag", err_overrun, 1);
    mem_model[5] = 8'hA5;
`ifdef MEM_RESP_PARITY_EN
    perr_model[5] = 1'b0;
`endif
    acc_model++;
    check("ovr_acc", acc_count, acc_model);
    count_ready(4, seen);
    check("ovr_read_dropped", seen, 0);
    access(1'b0, 5'd5, 8'h00, 1'b0);

    // Reset during WAIT of a write abandons it
    write = 1'b1; addr = 5'd7; data_in = 8'h3C;
    @(posedge clk); #1;
    write = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 5'd7, 8'h00, 1'b0);

`ifdef MEM_RESP_PARITY_EN
    access(1'b1, 5'd2, 8'h0F, 1'b1);
    access(1'b0, 5'd2, 8'h00, 1'b0);
    check("perr_inj_flag", rd_perr, 1);
    access(1'b1, 5'd2, 8'h0F, 1'b0);
    access(1'b0, 5'd2, 8'h00, 1'b0);
    check("perr_clean_flag", rd_perr, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
